wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Round-robin Wishbone arbiter letting NUM_MASTERS masters share one Wishbone slave (ROM/RAM port).
//  Grant is locked for the whole cyc of the winner, so slave-side bursts (cti/bte) pass through intact.
//  Sits between the bus masters (CPU I/D ports, DMA) and a single memory slave.
// PARAMETERS
//  NUM_MASTERS    2    number of requesting masters (2..8)
//  WB_ADDR_BITS   32   Wishbone address width
//  WORD_BYTES     4    bytes per word; WORD_BITS = 8*WORD_BYTES
//  TIMEOUT_CYCLES 255  no-ack cycles before error abort (WB_ARB_TIMEOUT_EN only), 1..255
// PORTS
//  wb_clk_i    in   1                        bus clock, all logic on rising edge
//  wb_rst_n_i  in   1                        reset, asynchronous assert, active-low
//  m_cyc_i     in   N                        master cyc, bit i = master i
//  m_stb_i     in   N                        master stb
//  m_addr_i    in   N*(WB_ADDR_BITS-2)       word addresses [WB_ADDR_BITS-1:2], master i at slice i
//  m_cti_i     in   N*3                      cycle type ids
//  m_bte_i     in   N*2                      burst type extensions
//  m_sel_i     in   N*WORD_BYTES             byte selects
//  m_we_i      in   N                        write enables
//  m_data_i    in   N*WORD_BITS              write data
//  m_data_o    out  WORD_BITS                read data, broadcast to all masters
//  m_ack_o     out  N                        ack, only granted master's bit may be 1
//  m_err_o     out  N                        error (timeout abort), only granted bit
//  s_cyc_o/s_stb_o/s_we_o out 1              to slave
//  s_addr_o    out  WB_ADDR_BITS-2 ; s_cti_o out 3 ; s_bte_o out 2 ; s_sel_o out WORD_BYTES
//  s_data_o    out  WORD_BITS ; s_data_i in WORD_BITS ; s_ack_i in 1
//  gnt_o       out  N                        registered one-hot grant (all 0 when idle)
// BEHAVIOUR
//  - Reset: state=IDLE, gnt_o=0, last-granted pointer=N-1 (master 0 wins first), counter=0.
//    All s_* control outputs, m_ack_o, m_err_o = 0 during and after reset; data outputs don't-care.
//  - FSM IDLE -> BUS -> (ERR) -> IDLE.
//  - IDLE: if any m_cyc_i set, pick first requester searching from (last+1) mod N upward with wrap;
//    next edge: gnt_o one-hot, last=winner, state=BUS. No requesters: stay IDLE.
//  - BUS: s_cyc/stb/we/addr/cti/bte/sel/data = granted master's inputs (combinational mux on gnt_o);
//    m_ack_o[g]=s_ack_i, other bits 0; m_data_o=s_data_i. Arbiter adds zero latency inside a grant.
//  - Release: granted m_cyc_i low at an edge -> gnt_o=0, state=IDLE; one-cycle bubble before next grant.
//    s_cyc_o must read 0 in the cycle the master drops cyc (mux follows m_cyc_i directly).
//  - Non-granted masters' cyc/stb ignored; they see ack=err=0 until granted. No preemption.
//  - Simultaneous requests: strict rotation; a master requesting continuously is served at least
//    once per N grants. Request and release by different masters on same edge: release wins, arb next cycle.
//  - Only s_ack_i seen while stb high is forwarded; spurious s_ack_i in IDLE is dropped.
//  - Async reset mid-transfer: grant dropped immediately, s_cyc_o=0 combinationally.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - 8-bit counter in BUS, cleared on s_ack_i, on stb low, and on entering BUS; else +1.
//   - counter==TIMEOUT_CYCLES with stb high and no ack: state=ERR for the next cycle:
//     s_cyc_o=s_stb_o=0, m_err_o[g]=1 for exactly one cycle, then remain ERR (err=0, s_cyc=0)
//     until granted m_cyc_i drops, then IDLE.
//  Not defined: no counter, no ERR state, m_err_o tied 0; a hung slave holds the grant forever.
// TESTING
//  - Reset: hold wb_rst_n_i=0 with m_cyc_i=2'b11 -> gnt_o=0, s_cyc_o=0, m_ack_o=0; release -> gnt_o=2'b01 one edge later.
//  - Single read: master 1 cyc/stb addr 0x40 -> gnt_o=2'b10, s_addr_o=0x40, ack with slave data 0xDEADBEEF on m_data_o, m_ack_o=2'b10.
//  - Round-robin: both masters hold cyc, each drops after one ack -> grants 0,1,0,1 with one idle cycle between.
//  - Burst: master 0 cti=3'b010 bte=0 sel=4'hF, 4 acks -> grant held all 4 beats while master 1 requests; master 1 granted after.
//  - Release race: master 0 drops cyc same edge master 1 raises -> IDLE one cycle, then gnt_o=2'b10; no ack to master 1 before grant.
//  - Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never acks -> m_err_o[0] single pulse, s_cyc_o=0 after; without macro grant holds 100+ cycles.

Source files
------------

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter; the winner keeps the slave for its whole cyc so bursts pass intact.
// Optional no-ack watchdog with error abort enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned WB_ADDR_BITS   = 32,
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                      wb_clk_i,
  input  logic                                      wb_rst_n_i,
  input  logic [NUM_MASTERS-1:0]                    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                    m_stb_i,
  input  logic [NUM_MASTERS*(WB_ADDR_BITS-2)-1:0]   m_addr_i,
  input  logic [NUM_MASTERS*3-1:0]                  m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]                  m_bte_i,
  input  logic [NUM_MASTERS*WORD_BYTES-1:0]         m_sel_i,
  input  logic [NUM_MASTERS-1:0]                    m_we_i,
  input  logic [NUM_MASTERS*8*WORD_BYTES-1:0]       m_data_i,
  output logic [8*WORD_BYTES-1:0]                   m_data_o,
  output logic [NUM_MASTERS-1:0]                    m_ack_o,
  output logic [NUM_MASTERS-1:0]                    m_err_o,
  output logic                                      s_cyc_o,
  output logic                                      s_stb_o,
  output logic                                      s_we_o,
  output logic [WB_ADDR_BITS-3:0]                   s_addr_o,
  output logic [2:0]                                s_cti_o,
  output logic [1:0]                                s_bte_o,
  output logic [WORD_BYTES-1:0]                     s_sel_o,
  output logic [8*WORD_BYTES-1:0]                   s_data_o,
  input  logic [8*WORD_BYTES-1:0]                   s_data_i,
  input  logic                                      s_ack_i,
  output logic [NUM_MASTERS-1:0]                    gnt_o
);

  localparam int unsigned AW        = WB_ADDR_BITS - 2;
  localparam int unsigned WORD_BITS = 8 * WORD_BYTES;
  localparam int unsigned IDX_W     = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("wb_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES 1..255");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUS = 2'd1, ST_ERR = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUS = 2'd1} state_e;
`endif

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   found;
  int                     idx;
  logic                   sel_cyc;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       timeout_hit;

  assign timeout_hit = m_stb_i[last_q] && !s_ack_i && (cnt_q == 8'(TIMEOUT_CYCLES));
`endif

  // State, grant and rotation pointer
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state: rotate search from last+1, hold grant until the winner drops cyc
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    found   = 1'b0;
    idx     = 0;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef WB_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
          if (!found && m_cyc_i[(int'(last_q) + k) % int'(NUM_MASTERS)]) begin
            found = 1'b1;
            idx   = (int'(last_q) + k) % int'(NUM_MASTERS);
          end
        end
        if (found) begin
          state_d    = ST_BUS;
          gnt_d      = '0;
          gnt_d[idx] = 1'b1;
          last_d     = IDX_W'(idx);
        end
      end
      ST_BUS: begin
        if (!m_cyc_i[last_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else if (s_ack_i || !m_stb_i[last_q]) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_ERR: begin
        if (!m_cyc_i[last_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Slave-side mux follows the granted master's live inputs for zero added latency
  assign sel_cyc  = (state_q == ST_BUS) && m_cyc_i[last_q];
  assign s_cyc_o  = sel_cyc;
  assign s_stb_o  = sel_cyc && m_stb_i[last_q];
  assign s_we_o   = sel_cyc && m_we_i[last_q];
  assign s_addr_o = m_addr_i[int'(last_q)*AW +: AW];
  assign s_cti_o  = m_cti_i[int'(last_q)*3 +: 3];
  assign s_bte_o  = m_bte_i[int'(last_q)*2 +: 2];
  assign s_sel_o  = m_sel_i[int'(last_q)*WORD_BYTES +: WORD_BYTES];
  assign s_data_o = m_data_i[int'(last_q)*WORD_BITS +: WORD_BITS];

  assign m_data_o = s_data_i;
  assign m_ack_o  = (s_stb_o && s_ack_i) ? gnt_q : '0;
  assign gnt_o    = gnt_q;

`ifdef WB_ARB_TIMEOUT_EN
  assign m_err_o  = err_q ? gnt_q : '0;
`else
  assign m_err_o  = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter with two masters; ack beats are queued when driven and popped on m_ack_o.
module tb_wb_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 30;
  localparam int unsigned TO = 8;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    m_cyc, m_stb, m_we;
  logic [59:0]   m_addr;
  logic [5:0]    m_cti;
  logic [3:0]    m_bte;
  logic [7:0]    m_sel;
  logic [63:0]   m_data;
  logic [31:0]   m_data_o;
  logic [1:0]    m_ack_o, m_err_o, gnt_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [29:0]   s_addr_o;
  logic [2:0]    s_cti_o;
  logic [1:0]    s_bte_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_data_o;
  logic [31:0]   s_data;
  logic          s_ack;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  wb_arbiter #(
    .NUM_MASTERS(N), .WB_ADDR_BITS(32), .WORD_BYTES(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_addr_i(m_addr), .m_cti_i(m_cti),
    .m_bte_i(m_bte), .m_sel_i(m_sel), .m_we_i(m_we), .m_data_i(m_data),
    .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_sel_o(s_sel_o), .s_data_o(s_data_o),
    .s_data_i(s_data), .s_ack_i(s_ack), .gnt_o(gnt_o)
  );

  // Scoreboard: every forwarded ack must match the oldest queued beat
  always @(negedge clk) begin
    beat_t       e;
    logic [1:0]  ea;
    #4;
    if (rst_n && m_ack_o !== 2'b00) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: m_ack_o=%b m_data_o=%h with no beat queued", m_ack_o, m_data_o);
      end else begin
        e = exp_q.pop_front();
        ea = 2'b00;
        ea[e.idx] = 1'b1;
        if (m_ack_o !== ea || m_data_o !== e.data) begin
          n_fail++;
          $display("FAIL beat: got ack=%b data=%h want ack=%b data=%h", m_ack_o, m_data_o, ea, e.data);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_beat(input int idx, input logic [31:0] d);
    beat_t b;
    b.idx  = idx;
    b.data = d;
    exp_q.push_back(b);
  endtask

  task automatic wait_gnt(output logic [1:0] g, output int waited);
    waited = 0;
    while (gnt_o === 2'b00 && waited < 20) begin
      step();
      waited++;
    end
    g = gnt_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
    repeat (3) step();
    #1;
    n_checks++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: gnt=%b s_cyc=%b s_stb=%b want 00/0/0", gnt_o, s_cyc_o, s_stb_o);
    end
    n_checks++;
    if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ack: ack=%b err=%b want 00/00", m_ack_o, m_err_o);
    end
    s_ack = 1'b0;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_first_gnt: got %b want 01", gnt_o);
    end
    m_cyc = 2'b00; m_stb = 2'b00;
    #1;
    n_checks++;
    if (s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_cyc_comb: s_cyc_o=%b want 0", s_cyc_o);
    end
    step();
    n_checks++;
    if (gnt_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b want 00", gnt_o);
    end
  endtask

  task automatic test_single_read();
    logic [1:0] g;
    int         w;
    s_ack = 1'b1;
    #1;
    n_checks++;
    if (m_ack_o !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_spurious_ack: got %b want 00", m_ack_o);
    end
    s_ack = 1'b0;
    m_addr[59:30] = 30'h40; m_we = 2'b00; m_cyc = 2'b10; m_stb = 2'b10;
    wait_gnt(g, w);
    #1;
    n_checks++;
    if (g !== 2'b10) begin
      n_fail++;
      $display("FAIL single_gnt: got %b want 10", g);
    end
    n_checks++;
    if (s_addr_o !== 30'h40 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_mux: addr=%h cyc=%b stb=%b we=%b want 40/1/1/0", s_addr_o, s_cyc_o, s_stb_o, s_we_o);
    end
    s_data = 32'hDEADBEEF; s_ack = 1'b1;
    push_beat(1, 32'hDEADBEEF);
    #1;
    n_checks++;
    if (m_ack_o !== 2'b10 || m_data_o !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_ack: ack=%b data=%h want 10/deadbeef", m_ack_o, m_data_o);
    end
    step();
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    step();
    n_checks++;
    if (gnt_o !== 2'b00) begin
      n_fail++;
      $display("FAIL single_release: got %b want 00", gnt_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g, eg;
    int         w, mi;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    for (int i = 0; i < 4; i++) begin
      mi = i % 2;
      eg = (mi == 0) ? 2'b01 : 2'b10;
      wait_gnt(g, w);
      n_checks++;
      if (g !== eg || w !== 1) begin
        n_fail++;
        $display("FAIL rr_gnt%0d: got %b after %0d idle want %b after 1", i, g, w, eg);
      end
      s_data = 32'h1000 + 32'(i); s_ack = 1'b1;
      push_beat(mi, 32'h1000 + 32'(i));
      step();
      s_ack = 1'b0;
      m_cyc[mi] = 1'b0; m_stb[mi] = 1'b0;
      if (i == 3) begin
        m_cyc = 2'b00; m_stb = 2'b00;
      end
      #1;
      n_checks++;
      if (s_cyc_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_drop%0d: s_cyc_o=%b want 0", i, s_cyc_o);
      end
      step();
      n_checks++;
      if (gnt_o !== 2'b00) begin
        n_fail++;
        $display("FAIL rr_bubble%0d: gnt=%b want 00", i, gnt_o);
      end
      if (i != 3) begin
        m_cyc[mi] = 1'b1; m_stb[mi] = 1'b1;
      end
    end
  endtask

  task automatic test_burst();
    logic [1:0] g;
    int         w;
    m_cti[2:0] = 3'b010; m_bte[1:0] = 2'b00; m_sel[3:0] = 4'hF; m_we = 2'b01;
    m_data[31:0] = 32'hCAFE0000; m_addr[29:0] = 30'h100;
    m_cyc = 2'b11; m_stb = 2'b11;
    wait_gnt(g, w);
    #1;
    n_checks++;
    if (g !== 2'b01) begin
      n_fail++;
      $display("FAIL burst_gnt: got %b want 01", g);
    end
    n_checks++;
    if (s_cti_o !== 3'b010 || s_bte_o !== 2'b00 || s_sel_o !== 4'hF || s_we_o !== 1'b1 ||
        s_data_o !== 32'hCAFE0000 || s_addr_o !== 30'h100) begin
      n_fail++;
      $display("FAIL burst_mux: cti=%b bte=%b sel=%h we=%b data=%h addr=%h want 010/00/f/1/cafe0000/100",
               s_cti_o, s_bte_o, s_sel_o, s_we_o, s_data_o, s_addr_o);
    end
    for (int b = 0; b < 4; b++) begin
      if (b == 3) m_cti[2:0] = 3'b111;
      s_ack = 1'b1; s_data = 32'hB000 + 32'(b);
      push_beat(0, 32'hB000 + 32'(b));
      #1;
      n_checks++;
      if (gnt_o !== 2'b01 || m_ack_o !== 2'b01) begin
        n_fail++;
        $display("FAIL burst_beat%0d: gnt=%b ack=%b want 01/01", b, gnt_o, m_ack_o);
      end
      step();
    end
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we = 2'b00; m_cti = '0;
    step();
    wait_gnt(g, w);
    n_checks++;
    if (g !== 2'b10 || w !== 1) begin
      n_fail++;
      $display("FAIL burst_next_gnt: got %b after %0d idle want 10 after 1", g, w);
    end
    m_cyc = 2'b00; m_stb = 2'b00;
    step();
  endtask

  task automatic test_release_race();
    logic [1:0] g;
    int         w;
    m_cyc = 2'b01; m_stb = 2'b01;
    wait_gnt(g, w);
    n_checks++;
    if (g !== 2'b01) begin
      n_fail++;
      $display("FAIL race_first_gnt: got %b want 01", g);
    end
    step();
    m_cyc = 2'b10; m_stb = 2'b10; s_ack = 1'b1;
    #1;
    n_checks++;
    if (m_ack_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL race_swap: ack=%b s_cyc=%b want 00/0", m_ack_o, s_cyc_o);
    end
    step();
    n_checks++;
    if (gnt_o !== 2'b00 || m_ack_o !== 2'b00) begin
      n_fail++;
      $display("FAIL race_idle: gnt=%b ack=%b want 00/00", gnt_o, m_ack_o);
    end
    s_ack = 1'b0;
    step();
    n_checks++;
    if (gnt_o !== 2'b10) begin
      n_fail++;
      $display("FAIL race_second_gnt: got %b want 10", gnt_o);
    end
    m_cyc = 2'b00; m_stb = 2'b00;
    step();
  endtask

  task automatic test_timeout();
    logic [1:0] g;
    int         w, n;
    m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0;
    wait_gnt(g, w);
    n_checks++;
    if (g !== 2'b01) begin
      n_fail++;
      $display("FAIL hang_gnt: got %b want 01", g);
    end
`ifdef WB_ARB_TIMEOUT_EN
    n = 0;
    while (m_err_o === 2'b00 && n < 40) begin
      step();
      n++;
    end
    n_checks++;
    if (m_err_o !== 2'b01 || n !== int'(TO) + 1 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err: err=%b after %0d cycles s_cyc=%b want 01 after %0d, 0",
               m_err_o, n, s_cyc_o, TO + 1);
    end
    step();
    n_checks++;
    if (m_err_o !== 2'b00 || s_cyc_o !== 1'b0 || gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_hold: err=%b s_cyc=%b gnt=%b want 00/0/01", m_err_o, s_cyc_o, gnt_o);
    end
`else
    n = 120;
    repeat (n) step();
    n_checks++;
    if (gnt_o !== 2'b01 || s_cyc_o !== 1'b1 || m_err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL hang_hold: gnt=%b s_cyc=%b err=%b after %0d cycles want 01/1/00", gnt_o, s_cyc_o, m_err_o, n);
    end
`endif
    m_cyc = 2'b00; m_stb = 2'b00;
    step();
    n_checks++;
    if (gnt_o !== 2'b00 || m_err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL hang_release: gnt=%b err=%b want 00/00", gnt_o, m_err_o);
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] g;
    int         w;
    m_cyc = 2'b10; m_stb = 2'b10;
    wait_gnt(g, w);
    n_checks++;
    if (g !== 2'b10) begin
      n_fail++;
      $display("FAIL areset_gnt: got %b want 10", g);
    end
    m_cyc = 2'b11; m_stb = 2'b11;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_drop: gnt=%b s_cyc=%b want 00/0", gnt_o, s_cyc_o);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL areset_regrant: got %b want 01", gnt_o);
    end
    m_cyc = 2'b00; m_stb = 2'b00;
    step();
  endtask

  initial begin
    rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_cti = '0;
    m_bte = '0; m_sel = '0; m_data = '0; s_data = '0; s_ack = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst();
    test_release_race();
    test_timeout();
    test_async_reset();
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL beats_left: %0d queued beats never acked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
